// File: rtl/ksa_engine.sv
// ksa_engine: RC4 key-scheduling engine driving an external single-port state RAM.
// First fills s[i] = i, then runs the KSA shuffle over the RAM using a latched key.
// Build option: define KSA_SHUFFLE_EN for init plus shuffle; leave it undefined for an
// init-only engine (identity fill, then done). The port list is the same in both builds.
module ksa_engine #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned KEY_BYTES = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [KEY_BYTES*DATA_W-1:0] key,
   output logic                        busy,
   output logic                        done,
   output logic [DATA_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   output logic                        mem_wren,
   input  logic [DATA_W-1:0]           mem_rdata
);

   localparam logic [DATA_W-1:0] LastIdx = '1;

`ifdef KSA_SHUFFLE_EN
   localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam logic [KW-1:0] LastKey = KW'(KEY_BYTES - 1);

   typedef enum logic [3:0] {
      StIdle, StInit, StRdI, StGetI, StRdJ, StGetJ, StWrI, StWrJ, StDone
   } state_e;
`else
   typedef enum logic [1:0] {StIdle, StInit, StDone} state_e;
`endif

   state_e            state_q, state_d;
   logic [DATA_W-1:0] i_q, i_d;

`ifdef KSA_SHUFFLE_EN
   logic [DATA_W-1:0]           j_q, j_d;
   logic [DATA_W-1:0]           si_q, si_d;
   logic [DATA_W-1:0]           sj_q, sj_d;
   logic [KEY_BYTES*DATA_W-1:0] key_q, key_d;
   logic [KW-1:0]               k_q, k_d;
   logic [DATA_W-1:0]           key_word;

   // Select key word k; word 0 sits in the most-significant slice of the key.
   always_comb begin
      key_word = '0;
      for (int unsigned w = 0; w < KEY_BYTES; w++) begin
         if (k_q == KW'(w)) key_word = key_q[(KEY_BYTES-1-w)*DATA_W +: DATA_W];
      end
   end
`else
   // key and mem_rdata have no consumer in the init-only build.
   logic unused_inputs;
   assign unused_inputs = ^{key, mem_rdata};
`endif

   // State and datapath registers; reset returns everything to idle immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         i_q     <= '0;
`ifdef KSA_SHUFFLE_EN
         j_q     <= '0;
         si_q    <= '0;
         sj_q    <= '0;
         key_q   <= '0;
         k_q     <= '0;
`endif
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
`ifdef KSA_SHUFFLE_EN
         j_q     <= j_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
         key_q   <= key_d;
         k_q     <= k_d;
`endif
      end
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
`ifdef KSA_SHUFFLE_EN
      j_d     = j_q;
      si_d    = si_q;
      sj_d    = sj_q;
      key_d   = key_q;
      k_d     = k_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StInit;
               i_d     = '0;
`ifdef KSA_SHUFFLE_EN
               j_d     = '0;
               k_d     = '0;
               key_d   = key;
`endif
            end
         end
         StInit: begin
            // Natural wrap brings i back to 0 after the last location.
            i_d = i_q + 1'b1;
            if (i_q == LastIdx) begin
`ifdef KSA_SHUFFLE_EN
               state_d = StRdI;
`else
               state_d = StDone;
`endif
            end
         end
`ifdef KSA_SHUFFLE_EN
         StRdI:  state_d = StGetI;
         StGetI: begin
            si_d    = mem_rdata;
            j_d     = j_q + mem_rdata + key_word;
            state_d = StRdJ;
         end
         StRdJ:  state_d = StGetJ;
         StGetJ: begin
            sj_d    = mem_rdata;
            state_d = StWrI;
         end
         StWrI:  state_d = StWrJ;
         StWrJ: begin
            i_d     = i_q + 1'b1;
            k_d     = (k_q == LastKey) ? '0 : k_q + 1'b1;
            state_d = (i_q == LastIdx) ? StDone : StRdI;
         end
`endif
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from state and registers only; mem_rdata never reaches them.
   always_comb begin
      busy      = (state_q != StIdle) && (state_q != StDone);
      done      = (state_q == StDone);
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wren  = 1'b0;
      unique case (state_q)
         StInit: begin
            mem_addr  = i_q;
            mem_wdata = i_q;
            mem_wren  = 1'b1;
         end
`ifdef KSA_SHUFFLE_EN
         StRdI: mem_addr = i_q;
         StRdJ: mem_addr = j_q;
         StWrI: begin
            mem_addr  = i_q;
            mem_wdata = sj_q;
            mem_wren  = 1'b1;
         end
         StWrJ: begin
            mem_addr  = j_q;
            mem_wdata = si_q;
            mem_wren  = 1'b1;
         end
`endif
         default: begin
            mem_addr  = '0;
            mem_wdata = '0;
            mem_wren  = 1'b0;
         end
      endcase
   end

endmodule
